// File: rtl/simple_router_pkg.sv
// Shared types for the simple_router / simple_merger pair.
//   NUM_PORTS   : number of lanes on the fan-out / fan-in side
//   port_idx_t  : encoded lane index
//   port_mask_t : one bit per lane
package simple_router_pkg;

   localparam int unsigned NUM_PORTS = 4;

   typedef logic [1:0] port_idx_t;
   typedef logic [3:0] port_mask_t;

endpackage

// File: rtl/simple_merger_if.sv
// Lane-side and output-side handshake bundle for simple_merger.
//   din0..din3 / din_en / din_rdy : four source lanes (valid/ready)
//   dout / dout_en / addr / dout_rdy : merged output lane with source tag
// Modports:
//   master : the environment (drives lanes, consumes the merged output)
//   slave  : the merger itself
interface simple_merger_if
   import simple_router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] din1;
   logic [DATA_WIDTH-1:0] din2;
   logic [DATA_WIDTH-1:0] din3;
   port_mask_t            din_en;
   port_mask_t            din_rdy;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_en;
   port_idx_t             addr;
   logic                  dout_rdy;

   modport master (
      output din0, din1, din2, din3, din_en, dout_rdy,
      input  din_rdy, dout, dout_en, addr
   );

   modport slave (
      input  din0, din1, din2, din3, din_en, dout_rdy,
      output din_rdy, dout, dout_en, addr
   );

endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter, purely combinational.
//   req       : request mask, one bit per lane
//   last      : index of the most recent grant (lowest priority this round)
//   gnt       : one-hot grant
//   idx       : encoded grant index
//   any_grant : at least one request present
module rr_arb4
   import simple_router_pkg::*;
(
   input  port_mask_t req,
   input  port_idx_t  last,
   output port_mask_t gnt,
   output port_idx_t  idx,
   output logic       any_grant
);

   port_idx_t cand;

   // Search last+1 .. last+4; the 2-bit add wraps modulo 4, so last itself
   // is considered last.
   always_comb begin
      gnt       = '0;
      idx       = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         cand = last + port_idx_t'(k);
         if (!any_grant && req[cand]) begin
            any_grant = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/simple_merger.sv
// Merges four source lanes onto one tagged output lane.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : simple_merger_if.slave (lane inputs, merged output + addr tag)
// Each lane has a one-entry holding buffer; din_rdy is simply "buffer empty".
// A round-robin arbiter loads a registered output stage whenever it is empty
// or being drained. dout/addr read as zero whenever dout_en is low.
module simple_merger
   import simple_router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
)(
   input  logic           clk,
   input  logic           rst,
   simple_merger_if.slave bus
);

   logic [DATA_WIDTH-1:0] din_arr   [NUM_PORTS];
   logic [DATA_WIDTH-1:0] hold_data [NUM_PORTS];
   port_mask_t            hold_vld;
   port_idx_t             last;

   logic [DATA_WIDTH-1:0] dout_q;
   logic                  dout_en_q;
   port_idx_t             addr_q;

   port_mask_t gnt;
   port_idx_t  gnt_idx;
   logic       any_grant;
   logic       load_ok;

   always_comb begin
      din_arr[0] = bus.din0;
      din_arr[1] = bus.din1;
      din_arr[2] = bus.din2;
      din_arr[3] = bus.din3;
   end

   assign load_ok = ~dout_en_q | bus.dout_rdy;

   rr_arb4 u_arb (
      .req       (hold_vld),
      .last      (last),
      .gnt       (gnt),
      .idx       (gnt_idx),
      .any_grant (any_grant)
   );

   // A lane never accepts and is granted on the same edge: accept needs
   // hold_vld=0, grant needs hold_vld=1, so the two hold_vld writes never
   // target the same bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_vld  <= '0;
         last      <= 2'd3;
         dout_q    <= '0;
         dout_en_q <= 1'b0;
         addr_q    <= '0;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            hold_data[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (bus.din_en[i] && !hold_vld[i]) begin
               hold_data[i] <= din_arr[i];
               hold_vld[i]  <= 1'b1;
            end
         end
         if (load_ok) begin
            if (any_grant) begin
               dout_q            <= hold_data[gnt_idx];
               addr_q            <= gnt_idx;
               dout_en_q         <= 1'b1;
               hold_vld[gnt_idx] <= 1'b0;
               last              <= gnt_idx;
            end else begin
               dout_q    <= '0;
               addr_q    <= '0;
               dout_en_q <= 1'b0;
            end
         end
      end
   end

   assign bus.din_rdy = ~hold_vld;
   assign bus.dout    = dout_q;
   assign bus.dout_en = dout_en_q;
   assign bus.addr    = addr_q;

   a_idle_zero : assert property (@(posedge clk) disable iff (!rst)
      !dout_en_q |-> (dout_q == '0) && (addr_q == '0));

   a_one_grant : assert property (@(posedge clk) disable iff (!rst)
      (load_ok && any_grant) |-> $onehot(gnt));

   a_stall_stable : assert property (@(posedge clk) disable iff (!rst)
      (dout_en_q && !bus.dout_rdy) |=>
         dout_en_q && $stable(dout_q) && $stable(addr_q));

endmodule

// File: tb/tb_simple_merger.sv
// Directed self-checking bench for simple_merger.
module tb_simple_merger;
   import simple_router_pkg::*;

   localparam int unsigned DW = 32;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   simple_merger_if #(.DATA_WIDTH(DW)) bus ();

   simple_merger #(.DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      @(posedge clk);
      #3;
      rst = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_en"},   64'(bus.dout_en), 64'd0);
      check({tag, "_dout"}, 64'(bus.dout),    64'd0);
      check({tag, "_addr"}, 64'(bus.addr),    64'd0);
   endtask

   // Fairness scoreboard
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q3[$];
   port_idx_t     exp_addr;

   task automatic sb_step();
      logic [DW-1:0] e;
      if (bus.dout_en) begin
         check("fair_addr", 64'(bus.addr), 64'(exp_addr));
         e = 'x;
         if (bus.addr == 2'd0 && q0.size() > 0) e = q0.pop_front();
         else if (bus.addr == 2'd3 && q3.size() > 0) e = q3.pop_front();
         check("fair_data", 64'(bus.dout), 64'(e));
         exp_addr = exp_addr ^ 2'd3;
      end
   endtask

   initial begin
      logic [DW-1:0] c0;
      logic [DW-1:0] c3;
      port_mask_t    acc;

      n_checks     = 0;
      n_errors     = 0;
      bus.din0     = '0;
      bus.din1     = '0;
      bus.din2     = '0;
      bus.din3     = '0;
      bus.din_en   = '0;
      bus.dout_rdy = 1'b1;
      rst          = 1'b0;
      #2;
      check("rst_rdy", 64'(bus.din_rdy), 64'hF);
      check_idle("rst");
      @(posedge clk);
      #3;
      rst = 1'b1;

      // Single word on lane 2
      bus.din2   = 32'hDEADBEEF;
      bus.din_en = 4'b0100;
      tick();
      bus.din_en = 4'b0000;
      check("t1_rdy_busy", 64'(bus.din_rdy), 64'hB);
      check("t1_en_early", 64'(bus.dout_en), 64'd0);
      tick();
      check("t1_en",   64'(bus.dout_en), 64'd1);
      check("t1_dout", 64'(bus.dout),    64'hDEADBEEF);
      check("t1_addr", 64'(bus.addr),    64'd2);
      check("t1_rdy_back", 64'(bus.din_rdy), 64'hF);
      tick();
      check_idle("t1_after");

      // All four lanes on the same edge from a fresh pointer
      do_reset();
      bus.din0   = 32'h10;
      bus.din1   = 32'h11;
      bus.din2   = 32'h12;
      bus.din3   = 32'h13;
      bus.din_en = 4'b1111;
      tick();
      bus.din_en = 4'b0000;
      check("t2_rdy_full", 64'(bus.din_rdy), 64'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_en",   64'(bus.dout_en), 64'd1);
         check("t2_addr", 64'(bus.addr),    64'(i));
         check("t2_dout", 64'(bus.dout),    64'(32'h10 + i));
      end
      tick();
      check_idle("t2_end");

      // Backpressure on lane 1
      bus.dout_rdy = 1'b0;
      bus.din1     = 32'hA5A5A5A5;
      bus.din_en   = 4'b0010;
      tick();
      bus.din_en   = 4'b0000;
      tick();
      check("t3_en0",   64'(bus.dout_en), 64'd1);
      check("t3_dout0", 64'(bus.dout),    64'hA5A5A5A5);
      bus.din1   = 32'h5A5A5A5A;
      bus.din_en = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.din_en = 4'b0000;
         check("t3_stall_en",   64'(bus.dout_en), 64'd1);
         check("t3_stall_dout", 64'(bus.dout),    64'hA5A5A5A5);
         check("t3_stall_addr", 64'(bus.addr),    64'd1);
         check("t3_stall_rdy",  64'(bus.din_rdy), 64'hD);
      end
      bus.dout_rdy = 1'b1;
      tick();
      check("t3_en1",   64'(bus.dout_en), 64'd1);
      check("t3_dout1", 64'(bus.dout),    64'h5A5A5A5A);
      check("t3_addr1", 64'(bus.addr),    64'd1);
      check("t3_rdy1",  64'(bus.din_rdy), 64'hF);
      tick();
      check_idle("t3_end");

      // Fairness between lanes 0 and 3
      do_reset();
      c0           = 32'h0000_1000;
      c3           = 32'h3000_0000;
      bus.din0     = c0;
      bus.din3     = c3;
      bus.din_en   = 4'b1001;
      bus.dout_rdy = 1'b1;
      exp_addr     = 2'd0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         acc = bus.din_en & bus.din_rdy;
         if (acc[0]) q0.push_back(bus.din0);
         if (acc[3]) q3.push_back(bus.din3);
         tick();
         if (acc[0]) begin c0 = c0 + 1; bus.din0 = c0; end
         if (acc[3]) begin c3 = c3 + 1; bus.din3 = c3; end
         sb_step();
      end
      bus.din_en = 4'b0000;
      for (int cyc = 0; cyc < 6; cyc++) begin
         tick();
         sb_step();
      end
      check("fair_q0_empty", 64'(q0.size()), 64'd0);
      check("fair_q3_empty", 64'(q3.size()), 64'd0);
      check_idle("fair_end");

      // Asynchronous reset while busy
      bus.dout_rdy = 1'b0;
      bus.din0     = 32'h100;
      bus.din1     = 32'h101;
      bus.din2     = 32'h102;
      bus.din3     = 32'h103;
      bus.din_en   = 4'b0100;
      tick();
      bus.din_en   = 4'b1011;
      tick();
      bus.din_en   = 4'b0000;
      check("t5_pre_en",  64'(bus.dout_en), 64'd1);
      check("t5_pre_rdy", 64'(bus.din_rdy), 64'h4);
      #2;
      rst = 1'b0;
      #1;
      check("t5_rdy", 64'(bus.din_rdy), 64'hF);
      check_idle("t5_rst");
      #1;
      rst = 1'b1;
      bus.dout_rdy = 1'b1;
      bus.din_en   = 4'b0101;
      tick();
      bus.din_en   = 4'b0000;
      tick();
      check("t5_first_addr", 64'(bus.addr), 64'd0);
      check("t5_first_dout", 64'(bus.dout), 64'h100);
      tick();
      check("t5_second_addr", 64'(bus.addr), 64'd2);
      check("t5_second_dout", 64'(bus.dout), 64'h102);
      tick();

      // Idle with no lane valid
      for (int i = 0; i < 10; i++) begin
         bus.din0 = $urandom;
         bus.din3 = $urandom;
         tick();
         check_idle("idle");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
